// File: rtl/platform_table_loader_pkg.sv
// Platform descriptor formats, slot counts and empty-slot constants shared by
// the table loader, color_mapper and the collision logic.
package platform_pkg;

  localparam int NUM_SLOTS       = 16;
  localparam int SLOTS_PER_LEVEL = 32;
  localparam int DESC_W          = 29;

  typedef struct packed {
    logic [9:0] length;
    logic [8:0] y_loc;
    logic [9:0] x_start;
  } ground_desc_t;

  typedef struct packed {
    logic [9:0] length;
    logic [9:0] x_loc;
    logic [8:0] y_start;
  } fence_desc_t;

  // Empty slots park their fixed coordinate off-screen so nothing draws or collides.
  localparam ground_desc_t EMPTY_GROUND = '{length: 10'd0, y_loc: 9'd511, x_start: 10'd0};
  localparam fence_desc_t  EMPTY_FENCE  = '{length: 10'd0, x_loc: 10'd1023, y_start: 9'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WAIT_FRAME
  } load_state_t;

  function automatic ground_desc_t to_ground(input logic [DESC_W-1:0] word);
    return ground_desc_t'(word);
  endfunction

  function automatic fence_desc_t to_fence(input logic [DESC_W-1:0] word);
    return fence_desc_t'(word);
  endfunction

endpackage

// File: rtl/platform_table_loader.sv
// Streams one level's 32 ROM descriptors into shadow tables and commits them on frame_start.
// Ready 1+32+ROM_LAT cycles after accept, then waits for vblank; no queueing, load_req ignored while busy.
module platform_table_loader
  import platform_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int LEVEL_W    = 2,
  parameter int ROM_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_req,
  input  logic [LEVEL_W-1:0]           level_id,
  input  logic                         frame_start,
  output logic [LEVEL_W+4:0]           rom_addr,
  input  logic [29:0]                  rom_data,
  output logic                         busy,
  output logic                         done,
  output logic                         load_err,
  output ground_desc_t [NUM_SLOTS-1:0] info_ground,
  output fence_desc_t  [NUM_SLOTS-1:0] info_fence
);

  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);

  load_state_t                  state_q, state_d;
  logic [LEVEL_W-1:0]           lvl_q;
  logic [4:0]                   slot_q;
  logic [1:0]                   drain_q;
  logic [ROM_LAT-1:0]           pipe_vld_q;
  logic [ROM_LAT-1:0][4:0]      pipe_idx_q;
  ground_desc_t [NUM_SLOTS-1:0] shadow_ground;
  fence_desc_t  [NUM_SLOTS-1:0] shadow_fence;
  logic                         done_q, err_q;
  logic                         id_ok, accept, commit, cap_vld;
  logic [4:0]                   cap_idx;

  assign id_ok   = 32'(level_id) < 32'(NUM_LEVELS);
  assign accept  = (state_q == ST_IDLE) && load_req && id_ok;
  assign commit  = (state_q == ST_WAIT_FRAME) && frame_start;
  assign cap_vld = pipe_vld_q[ROM_LAT-1];
  assign cap_idx = pipe_idx_q[ROM_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (accept) state_d = ST_FETCH;
      ST_FETCH:      if (slot_q == 5'd31) state_d = ST_DRAIN;
      ST_DRAIN:      if (drain_q == DRAIN_LAST) state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (frame_start) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    rom_addr = {lvl_q, slot_q};
    done     = done_q;
    load_err = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= '0;
      slot_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= commit;
      err_q  <= (state_q == ST_IDLE) && load_req && !id_ok;
      if (accept) begin
        lvl_q  <= level_id;
        slot_q <= '0;
      end else if (state_q == ST_FETCH && slot_q != 5'd31) begin
        slot_q <= slot_q + 5'd1;
      end
      if (state_q == ST_FETCH)      drain_q <= '0;
      else if (state_q == ST_DRAIN) drain_q <= drain_q + 2'd1;
    end
  end

  // Each issued address travels with its slot index so the returning word lands in the right shadow slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      pipe_vld_q[0] <= (state_q == ST_FETCH);
      pipe_idx_q[0] <= slot_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_ground[i] <= EMPTY_GROUND;
        shadow_fence[i]  <= EMPTY_FENCE;
      end
    end else if (cap_vld) begin
      if (cap_idx[4])
        shadow_fence[cap_idx[3:0]]  <= rom_data[29] ? to_fence(rom_data[28:0]) : EMPTY_FENCE;
      else
        shadow_ground[cap_idx[3:0]] <= rom_data[29] ? to_ground(rom_data[28:0]) : EMPTY_GROUND;
    end
  end

  // Active tables move only on the commit edge so a frame never sees a half-loaded level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        info_ground[i] <= EMPTY_GROUND;
        info_fence[i]  <= EMPTY_FENCE;
      end
    end else if (commit) begin
      info_ground <= shadow_ground;
      info_fence  <= shadow_fence;
    end
  end

endmodule

// File: tb/tb_platform_table_loader.sv
// Drives three loaders (ROM_LAT 1..3) with one stimulus stream; a level-granular model
// predicts per-cycle outputs into a stamped queue that a negedge monitor drains.
module tb_platform_table_loader;
  import platform_pkg::*;

  localparam int NI  = 3;
  localparam int NLV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_req = 1'b0;
  logic [1:0] level_id = '0;
  logic       frame_start = 1'b0;
  logic       end_req = 1'b0;

  logic [29:0] rom [128];

  logic [6:0]                   rom_addr_w [NI];
  logic                         busy_w [NI];
  logic                         done_w [NI];
  logic                         err_w [NI];
  ground_desc_t [NUM_SLOTS-1:0] g_w [NI];
  fence_desc_t  [NUM_SLOTS-1:0] f_w [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = k + 1;
    logic [29:0] pipe [L];

    always @(posedge clk) begin
      pipe[0] <= rom[rom_addr_w[k]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    platform_table_loader #(.NUM_LEVELS(NLV), .LEVEL_W(2), .ROM_LAT(L)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_req   (load_req),
      .level_id   (level_id),
      .frame_start(frame_start),
      .rom_addr   (rom_addr_w[k]),
      .rom_data   (pipe[L-1]),
      .busy       (busy_w[k]),
      .done       (done_w[k]),
      .load_err   (err_w[k]),
      .info_ground(g_w[k]),
      .info_fence (f_w[k])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic       busy;
    logic       done;
    logic       err;
    logic       addr_chk;
    logic [6:0] addr;
    int         act;
  } exp_t;

  exp_t exp_q[$];

  // Model: level-granular view of the loader (who is loading, since when, which level is live).
  logic m_busy = 1'b0;
  int   m_acc = 0;
  int   m_lvl = 0;
  int   m_act = -1;

  function automatic logic [463:0] exp_g(input int act);
    ground_desc_t [15:0] t;
    logic [29:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (act < 0) ? 30'd0 : rom[act*32 + i];
      t[i] = w[29] ? ground_desc_t'(w[28:0]) : EMPTY_GROUND;
    end
    return 464'(t);
  endfunction

  function automatic logic [463:0] exp_f(input int act);
    fence_desc_t [15:0] t;
    logic [29:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (act < 0) ? 30'd0 : rom[act*32 + 16 + i];
      t[i] = w[29] ? fence_desc_t'(w[28:0]) : EMPTY_FENCE;
    end
    return 464'(t);
  endfunction

  task automatic step(input logic lr, input logic [1:0] lid, input logic fs);
    exp_t e;
    int t;
    @(posedge clk);
    #1;
    t = cyc + 1;
    // Commit edge differs by ROM_LAT across instances; keep frame_start out of that window.
    if (m_busy && (t - m_acc) >= 33 && (t - m_acc) <= 35) fs = 1'b0;
    load_req    = lr;
    level_id    = lid;
    frame_start = fs;
    e.done = 1'b0;
    e.err  = 1'b0;
    if (rst_n) begin
      if (!m_busy) begin
        if (lr) begin
          if (int'(lid) < NLV) begin
            m_busy = 1'b1;
            m_acc  = t;
            m_lvl  = int'(lid);
          end else begin
            e.err = 1'b1;
          end
        end
      end else if (fs && (t - m_acc) >= 36) begin
        m_busy = 1'b0;
        m_act  = m_lvl;
        e.done = 1'b1;
      end
      e.stamp    = t;
      e.busy     = m_busy;
      e.act      = m_act;
      e.addr_chk = m_busy && (t - m_acc) <= 31;
      e.addr     = 7'(m_lvl * 32 + (t - m_acc));
      exp_q.push_back(e);
    end
  endtask

  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_act  = -1;
    exp_q.delete();
    repeat (hold) step(1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    for (int a = 0; a < 128; a++)
      rom[a] = {($urandom_range(0, 4) != 0), 29'($urandom)};
    for (int i = 0; i < 32; i++)
      rom[32 + i] = {1'b1, 10'($urandom), 9'($urandom), (i < 16) ? 10'(i * 40) : 10'($urandom)};
    rom[64 + 5][29]  = 1'b0;
    rom[64 + 20][29] = 1'b0;

    async_reset(3);

    // Level 1; stray frame_start mid-fetch and a second request while busy.
    step(1'b1, 2'd1, 1'b0);
    for (int o = 1; o <= 45; o++) step(o == 5, 2'd2, (o == 10) || (o == 45));
    repeat (2) step(1'b0, 2'd0, 1'b0);

    // Level 2 with invalid slots 5 and 20.
    step(1'b1, 2'd2, 1'b0);
    for (int o = 1; o <= 40; o++) step(1'b0, 2'd0, o == 40);
    repeat (2) step(1'b0, 2'd0, 1'b0);

    // Out-of-range level.
    step(1'b1, 2'd3, 1'b0);
    repeat (3) step(1'b0, 2'd0, 1'b0);

    // Reset at slot 17 of a load over a committed level, then reload level 1.
    step(1'b1, 2'd0, 1'b0);
    for (int o = 1; o <= 17; o++) step(1'b0, 2'd0, 1'b0);
    async_reset(2);
    step(1'b1, 2'd1, 1'b0);
    for (int o = 1; o <= 40; o++) step(1'b0, 2'd0, o == 38);

    repeat (400)
      step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
    repeat (40) step(1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b0);

    @(posedge clk);
    @(posedge clk);
    #1 end_req = 1'b1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int k, input logic [463:0] act, input logic [463:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s lat%0d cyc%0d: got %h want %h", nm, k + 1, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int k = 0; k < NI; k++) begin
          chk("rst_busy", k, 464'(busy_w[k]), 464'(0));
          chk("rst_done", k, 464'(done_w[k]), 464'(0));
          chk("rst_err", k, 464'(err_w[k]), 464'(0));
          chk("rst_addr", k, 464'(rom_addr_w[k]), 464'(0));
          chk("rst_ground", k, 464'(g_w[k]), exp_g(-1));
          chk("rst_fence", k, 464'(f_w[k]), exp_f(-1));
        end
      end else if (end_req) begin
        chk("pending", 0, 464'(exp_q.size()), 464'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        e = exp_q.pop_front();
        chk("stamp", 0, 464'(e.stamp), 464'(cyc));
        for (int k = 0; k < NI; k++) begin
          chk("busy", k, 464'(busy_w[k]), 464'(e.busy));
          chk("done", k, 464'(done_w[k]), 464'(e.done));
          chk("load_err", k, 464'(err_w[k]), 464'(e.err));
          if (e.addr_chk) chk("rom_addr", k, 464'(rom_addr_w[k]), 464'(e.addr));
          chk("ground", k, 464'(g_w[k]), exp_g(e.act));
          chk("fence", k, 464'(f_w[k]), exp_f(e.act));
          if (e.done && e.act == 1) chk("g3_xstart", k, 464'(g_w[k][3].x_start), 464'(120));
          if (e.done && e.act == 2) begin
            chk("g5_empty", k, 464'(g_w[k][5]), 464'(EMPTY_GROUND));
            chk("f4_empty", k, 464'(f_w[k][4]), 464'(EMPTY_FENCE));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
